// File: rtl/cpu_tx_arbiter_if.sv
// cpu_tx_arbiter_if: per-port request queues, merged stream and status of the CPU transmit arbiter
interface cpu_tx_arbiter_if #(
    parameter int C_DATA_WIDTH = 256,
    parameter int NUM_PORTS    = 4
);
    localparam int PTR_W  = $clog2(NUM_PORTS);
    localparam int KEEP_W = C_DATA_WIDTH / 8;
    logic [NUM_PORTS-1:0]              port_en;
    logic [NUM_PORTS*C_DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_PORTS*KEEP_W-1:0]       s_axis_tkeep;
    logic [NUM_PORTS-1:0]              s_axis_tvalid;
    logic [NUM_PORTS-1:0]              s_axis_tlast;
    logic [NUM_PORTS-1:0]              s_axis_tready;
    logic [C_DATA_WIDTH-1:0]           m_axis_tdata;
    logic [KEEP_W-1:0]                 m_axis_tkeep;
    logic                              m_axis_tvalid;
    logic                              m_axis_tlast;
    logic                              m_axis_tready;
    logic [PTR_W-1:0]                  grant;
    logic                              busy;
    modport master (
        input  port_en, s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, grant, busy
    );
    modport slave (
        output port_en, s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, grant, busy
    );
endinterface

// File: rtl/cpu_tx_arbiter.sv
// cpu_tx_arbiter: packet-level round-robin merge of NUM_PORTS CPU transmit AXI-Stream queues
module cpu_tx_arbiter #(
    parameter int C_DATA_WIDTH = 256,
    parameter int NUM_PORTS    = 4
) (
    input logic              clk,
    input logic              rst,
    cpu_tx_arbiter_if.master bus
);
    localparam int PTR_W  = $clog2(NUM_PORTS);
    localparam int KEEP_W = C_DATA_WIDTH / 8;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [PTR_W-1:0]        grant_q, grant_d, last_grant_q, last_grant_d, win, idx;
    logic [NUM_PORTS-1:0]    req;
    logic                    found, send, fin;
    logic [C_DATA_WIDTH-1:0] dat [NUM_PORTS];
    logic [KEEP_W-1:0]       kep [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slice
        assign dat[i] = bus.s_axis_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
        assign kep[i] = bus.s_axis_tkeep[i*KEEP_W +: KEEP_W];
    end

    assign req  = bus.s_axis_tvalid & bus.port_en;
    assign send = state_q == SEND;
    assign fin  = bus.m_axis_tvalid & bus.m_axis_tready & bus.m_axis_tlast;

    // first requester after the previous winner, so the winner drops to lowest priority
    always_comb begin
        win   = grant_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = PTR_W'((int'(last_grant_q) + k) % NUM_PORTS);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign state_d      = send ? (fin ? IDLE : SEND) : (found ? SEND : IDLE);
    assign grant_d      = (!send && found) ? win : grant_q;
    assign last_grant_d = (send && fin) ? grant_q : last_grant_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= PTR_W'(NUM_PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.m_axis_tdata  = dat[grant_q];
    assign bus.m_axis_tkeep  = kep[grant_q];
    assign bus.m_axis_tvalid = send & bus.s_axis_tvalid[grant_q];
    assign bus.m_axis_tlast  = bus.s_axis_tlast[grant_q];
    assign bus.grant         = grant_q;
    assign bus.busy          = send;

    always_comb begin
        bus.s_axis_tready          = '0;
        bus.s_axis_tready[grant_q] = send & bus.m_axis_tready;
    end

    a_onehot_ready: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.s_axis_tready));
    a_packet_lock:  assert property (@(posedge clk) disable iff (rst)
        (send && !fin) |=> (send && $stable(grant_q)));
endmodule

// File: tb/tb_cpu_tx_arbiter.sv
// tb_cpu_tx_arbiter: scenario tasks plus randomized traffic scored against a round-robin packet model
module tb_cpu_tx_arbiter;
    localparam int W = 64;
    localparam int N = 4;
    localparam int K = W / 8;
    typedef struct packed {logic [W-1:0] d; logic [K-1:0] k; logic l;} beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_tx_arbiter_if #(.C_DATA_WIDTH(W), .NUM_PORTS(N)) bus ();
    cpu_tx_arbiter #(.C_DATA_WIDTH(W), .NUM_PORTS(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    beat_t src_q [N][$];
    beat_t exp_q [N][$];
    bit rdy_q[$];
    int order_q[$];
    int checks = 0, errors = 0;
    int data_bad = 0, arb_bad = 0, arb_n = 0, bubble_bad = 0, idle_bad = 0, rdy_bad = 0;
    int stall_n = 0, beats_out = 0, gap_pct = 0, pend_win = 0, last_m = N - 1, seq = 0, mp = 0;
    bit rdy_rand = 0, pend = 0, after_last = 0, in_pkt = 0;
    logic [N-1:0] hold = '0;
    beat_t pb;
    logic pv;

    // winner = first requester after the previous winner, wrapping around
    function automatic int rr(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic add_pkt(input int p, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = {(i == 0) ? 8'hA5 : 8'($urandom), 32'($urandom), 8'(seq), 8'(p), 8'(i)};
            b.k = (i == len - 1) ? 8'($urandom_range(255, 1)) : '1;
            b.l = (i == len - 1);
            src_q[p].push_back(b);
            exp_q[p].push_back(b);
        end
        seq++;
    endtask

    // sources, sink and scoreboard: drive on negedge, observe 1 ns later
    initial begin
        bus.s_axis_tvalid = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tlast  = '0;
        bus.m_axis_tready = 1'b0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < N; p++) begin
                pb = '0;
                if (src_q[p].size() != 0) pb = src_q[p][0];
                pv = src_q[p].size() != 0 && !hold[p] && $urandom_range(99) >= gap_pct;
                bus.s_axis_tvalid[p]      = pv;
                bus.s_axis_tdata[p*W +: W] = pb.d;
                bus.s_axis_tkeep[p*K +: K] = pb.k;
                bus.s_axis_tlast[p]       = pb.l;
            end
            if (rdy_q.size() != 0) bus.m_axis_tready = rdy_q.pop_front();
            else bus.m_axis_tready = rdy_rand ? ($urandom_range(3) != 0) : 1'b1;
            #1;
            if (!rst) begin
                if (pend) begin
                    arb_n++;
                    if (!bus.busy || int'(bus.grant) != pend_win) arb_bad++;
                    pend = 0;
                end
                if (after_last && bus.busy) bubble_bad++;
                after_last = 0;
                if (!bus.busy && bus.m_axis_tvalid) idle_bad++;
                for (int i = 0; i < N; i++)
                    if (bus.s_axis_tready[i] !== (bus.busy && int'(bus.grant) == i && bus.m_axis_tready)) rdy_bad++;
                if (bus.busy && bus.m_axis_tvalid && !bus.m_axis_tready) stall_n++;
                if (!bus.busy && (bus.s_axis_tvalid & bus.port_en) != 0) begin
                    pend = 1;
                    pend_win = rr(last_m, bus.s_axis_tvalid & bus.port_en);
                end
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    mp = int'(bus.m_axis_tdata[15:8]);
                    if (!in_pkt) order_q.push_back(int'(bus.grant));
                    if (mp >= N || mp != int'(bus.grant) || exp_q[mp].size() == 0) data_bad++;
                    else if (exp_q[mp][0] !== {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast}) data_bad++;
                    else void'(exp_q[mp].pop_front());
                    beats_out++;
                    in_pkt = !bus.m_axis_tlast;
                    if (bus.m_axis_tlast) begin
                        last_m = int'(bus.grant);
                        after_last = 1;
                    end
                end
                for (int i = 0; i < N; i++)
                    if (bus.s_axis_tvalid[i] && bus.s_axis_tready[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        for (int p = 0; p < N; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
        end
        rdy_q.delete();
        order_q.delete();
        hold = '0;
        gap_pct = 0;
        rdy_rand = 0;
        bus.port_en = '1;
        data_bad = 0; arb_bad = 0; arb_n = 0; bubble_bad = 0; idle_bad = 0; rdy_bad = 0;
        stall_n = 0; beats_out = 0; pend = 0; after_last = 0; in_pkt = 0; last_m = N - 1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_idle(input logic [N-1:0] mask, input string name);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            #2;
            n++;
            done = !bus.busy && !pend;
            for (int p = 0; p < N; p++) if (mask[p] && src_q[p].size() != 0) done = 0;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s drain timeout: busy=%0b after %0d cycles, required idle", name, bus.busy, n);
        end
    endtask

    task automatic wait_beats(input int target, input string name);
        int n;
        n = 0;
        while (beats_out < target && n < 1000) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (beats_out < target) begin
            checks++;
            errors++;
            $display("FAIL %s beat timeout: beats=%0d, required %0d", name, beats_out, target);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b1;
        for (int p = 0; p < N; p++) add_pkt(p, 1);
        @(negedge clk);
        #2;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst busy: got %b required 0", bus.busy); end
        checks++;
        if (bus.grant !== 2'd0) begin errors++; $display("FAIL rst grant: got %0d required 0", bus.grant); end
        checks++;
        if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst m_tvalid: got %b required 0", bus.m_axis_tvalid); end
        checks++;
        if (bus.s_axis_tready !== 4'b0) begin errors++; $display("FAIL rst s_tready: got %b required 0000", bus.s_axis_tready); end
        rst = 1'b0;
        wait_idle('1, "rst");
        checks++;
        if (order_q.size() != 4 || order_q[0] != 0 || order_q[1] != 1 || order_q[2] != 2 || order_q[3] != 3) begin
            errors++;
            $display("FAIL rst order: got %p required '{0,1,2,3}", order_q);
        end
    endtask

    task automatic test_single_port();
        apply_reset();
        add_pkt(2, 3);
        wait_idle('1, "single");
        checks++;
        if (order_q.size() != 1 || order_q[0] != 2) begin errors++; $display("FAIL single order: got %p required '{2}", order_q); end
        checks++;
        if (beats_out != 3) begin errors++; $display("FAIL single beats: got %0d required 3", beats_out); end
        checks++;
        if (bus.grant !== 2'd2) begin errors++; $display("FAIL single grant: got %0d required 2", bus.grant); end
        checks++;
        if (exp_q[2].size() != 0) begin errors++; $display("FAIL single lost: %0d beats missing, required 0", exp_q[2].size()); end
        checks++;
        if ((data_bad | arb_bad | bubble_bad | idle_bad | rdy_bad) != 0) begin
            errors++;
            $display("FAIL single integrity: data=%0d arb=%0d bubble=%0d idle=%0d rdy=%0d required all 0", data_bad, arb_bad, bubble_bad, idle_bad, rdy_bad);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        apply_reset();
        for (int r = 0; r < 2; r++) for (int p = 0; p < N; p++) add_pkt(p, 2);
        wait_idle('1, "rr");
        ok = order_q.size() == 8;
        for (int i = 0; i < order_q.size(); i++) if (order_q[i] != i % N) ok = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL rr order: got %p required '{0,1,2,3,0,1,2,3}", order_q); end
        checks++;
        if (beats_out != 16 || arb_n != 8) begin errors++; $display("FAIL rr counts: beats=%0d arbs=%0d required 16 and 8", beats_out, arb_n); end
        checks++;
        if ((data_bad | arb_bad | bubble_bad | idle_bad | rdy_bad) != 0) begin
            errors++;
            $display("FAIL rr integrity: data=%0d arb=%0d bubble=%0d idle=%0d rdy=%0d required all 0", data_bad, arb_bad, bubble_bad, idle_bad, rdy_bad);
        end
    endtask

    task automatic test_gap();
        apply_reset();
        add_pkt(1, 5);
        wait_beats(2, "gap");
        @(posedge clk);
        #1;
        hold[1] = 1'b1;
        add_pkt(3, 2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #2;
            checks++;
            if (bus.m_axis_tvalid !== 1'b0 || bus.grant !== 2'd1 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL gap cycle %0d: m_tvalid=%b grant=%0d busy=%b required 0,1,1", c, bus.m_axis_tvalid, bus.grant, bus.busy);
            end
        end
        @(posedge clk);
        #1;
        hold[1] = 1'b0;
        wait_idle('1, "gap");
        checks++;
        if (order_q.size() != 2 || order_q[0] != 1 || order_q[1] != 3) begin errors++; $display("FAIL gap order: got %p required '{1,3}", order_q); end
        checks++;
        if ((data_bad | arb_bad | bubble_bad | idle_bad | rdy_bad) != 0) begin
            errors++;
            $display("FAIL gap integrity: data=%0d arb=%0d bubble=%0d idle=%0d rdy=%0d required all 0", data_bad, arb_bad, bubble_bad, idle_bad, rdy_bad);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        add_pkt(0, 4);
        wait_idle('1, "bp");
        checks++;
        if (stall_n != 2 || beats_out != 4) begin errors++; $display("FAIL bp pattern: stalls=%0d beats=%0d required 2 and 4", stall_n, beats_out); end
        rdy_rand = 1;
        for (int i = 0; i < 3; i++) add_pkt(0, 3);
        wait_idle('1, "bp_rand");
        checks++;
        if (beats_out != 13 || exp_q[0].size() != 0) begin errors++; $display("FAIL bp beats: got %0d left %0d required 13 left 0", beats_out, exp_q[0].size()); end
        checks++;
        if ((data_bad | arb_bad | bubble_bad | idle_bad | rdy_bad) != 0) begin
            errors++;
            $display("FAIL bp integrity: data=%0d arb=%0d bubble=%0d idle=%0d rdy=%0d required all 0", data_bad, arb_bad, bubble_bad, idle_bad, rdy_bad);
        end
    endtask

    task automatic test_port_en();
        apply_reset();
        bus.port_en = 4'b1010;
        for (int r = 0; r < 2; r++) for (int p = 0; p < N; p++) add_pkt(p, 2);
        wait_idle(4'b1010, "en");
        checks++;
        if (order_q.size() != 4 || order_q[0] != 1 || order_q[1] != 3 || order_q[2] != 1 || order_q[3] != 3) begin
            errors++;
            $display("FAIL en order: got %p required '{1,3,1,3}", order_q);
        end
        @(negedge clk);
        #2;
        checks++;
        if (bus.busy !== 1'b0 || bus.m_axis_tvalid !== 1'b0 || bus.s_axis_tvalid[0] !== 1'b1) begin
            errors++;
            $display("FAIL en disabled: busy=%b m_tvalid=%b s_tvalid0=%b required 0,0,1", bus.busy, bus.m_axis_tvalid, bus.s_axis_tvalid[0]);
        end
        apply_reset();
        bus.port_en = 4'b1010;
        add_pkt(1, 4);
        add_pkt(3, 2);
        wait_beats(1, "en_mid");
        @(posedge clk);
        #1;
        bus.port_en = 4'b1000;
        wait_idle(4'b1010, "en_mid");
        checks++;
        if (order_q.size() != 2 || order_q[0] != 1 || order_q[1] != 3 || exp_q[1].size() != 0) begin
            errors++;
            $display("FAIL en_mid order: got %p left %0d required '{1,3} left 0", order_q, exp_q[1].size());
        end
        checks++;
        if ((data_bad | arb_bad | bubble_bad | idle_bad | rdy_bad) != 0) begin
            errors++;
            $display("FAIL en integrity: data=%0d arb=%0d bubble=%0d idle=%0d rdy=%0d required all 0", data_bad, arb_bad, bubble_bad, idle_bad, rdy_bad);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        add_pkt(2, 4);
        wait_beats(1, "rstmid");
        @(negedge clk);
        #2;
        checks++;
        if (bus.busy !== 1'b1 || bus.m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid beat2: busy=%b m_tvalid=%b required 1,1", bus.busy, bus.m_axis_tvalid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.m_axis_tvalid !== 1'b0 || bus.s_axis_tready !== 4'b0 || bus.busy !== 1'b0 || bus.grant !== 2'd0) begin
            errors++;
            $display("FAIL rstmid same-cycle: m_tvalid=%b s_tready=%b busy=%b grant=%0d required 0,0000,0,0",
                bus.m_axis_tvalid, bus.s_axis_tready, bus.busy, bus.grant);
        end
        apply_reset();
        for (int p = N - 1; p >= 0; p--) add_pkt(p, 1);
        wait_idle('1, "rstmid");
        checks++;
        if (order_q.size() != 4 || order_q[0] != 0) begin errors++; $display("FAIL rstmid first winner: got %p required port 0 first", order_q); end
    endtask

    task automatic test_random();
        int left;
        apply_reset();
        gap_pct = 25;
        rdy_rand = 1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            if ($urandom_range(4) == 0) bus.port_en = 4'($urandom_range(15));
            add_pkt($urandom_range(N - 1), $urandom_range(1, 5));
        end
        @(posedge clk);
        #1;
        bus.port_en = '1;
        wait_idle('1, "random");
        left = 0;
        for (int p = 0; p < N; p++) left += exp_q[p].size();
        checks++;
        if (left != 0 || order_q.size() != 40) begin errors++; $display("FAIL random counts: left=%0d pkts=%0d required 0 and 40", left, order_q.size()); end
        checks++;
        if ((data_bad | arb_bad | bubble_bad | idle_bad | rdy_bad) != 0) begin
            errors++;
            $display("FAIL random integrity: data=%0d arb=%0d bubble=%0d idle=%0d rdy=%0d required all 0", data_bad, arb_bad, bubble_bad, idle_bad, rdy_bad);
        end
    endtask

    initial begin
        bus.port_en = '1;
        test_reset();
        test_single_port();
        test_round_robin();
        test_gap();
        test_backpressure();
        test_port_en();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
